// File: rtl/pool_mem_arbiter.sv
// Single-buffer ownership arbiter for the pool output memory: producer fills a frame, consumer drains it.
// Optional ownership watchdog enabled by defining POOL_ARB_TIMEOUT_EN (adds the timeout_err port).
module pool_mem_arbiter #(
    parameter int POOL_ADDR_WIDTH = 10,
    parameter int FRAME_CNT_WIDTH = 8,
    parameter int TIMEOUT_CYCLES  = 4096,
    parameter int TIMEOUT_WIDTH   = 13
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       prod_req,
    input  logic                       prod_done,
    input  logic [POOL_ADDR_WIDTH-1:0] prod_addr_a,
    input  logic [POOL_ADDR_WIDTH-1:0] prod_addr_b,
    input  logic                       prod_rden_a,
    input  logic                       prod_rden_b,
    input  logic                       prod_wren_a,
    input  logic                       prod_wren_b,
    input  logic                       cons_req,
    input  logic                       cons_done,
    input  logic [POOL_ADDR_WIDTH-1:0] cons_addr_a,
    input  logic [POOL_ADDR_WIDTH-1:0] cons_addr_b,
    input  logic                       cons_rden_a,
    input  logic                       cons_rden_b,
    input  logic                       cons_wren_a,
    input  logic                       cons_wren_b,
    output logic                       prod_gnt,
    output logic                       cons_gnt,
    output logic                       buf_full,
    output logic [POOL_ADDR_WIDTH-1:0] mem_addr_a,
    output logic [POOL_ADDR_WIDTH-1:0] mem_addr_b,
    output logic                       mem_rden_a,
    output logic                       mem_rden_b,
    output logic                       mem_wren_a,
    output logic                       mem_wren_b,
    output logic [FRAME_CNT_WIDTH-1:0] frame_cnt,
    output logic                       viol
`ifdef POOL_ARB_TIMEOUT_EN
    ,
    output logic                       timeout_err
`endif
);

    typedef enum logic [1:0] {S_EMPTY, S_PROD, S_FULL, S_CONS} state_t;

    state_t state;
    state_t state_next;

    logic prod_any_en;
    logic cons_any_en;

    assign prod_any_en = prod_rden_a | prod_rden_b | prod_wren_a | prod_wren_b;
    assign cons_any_en = cons_rden_a | cons_rden_b | cons_wren_a | cons_wren_b;

`ifdef POOL_ARB_TIMEOUT_EN
    logic [TIMEOUT_WIDTH-1:0] tmo_cnt;
    logic                     tmo_expired;

    assign tmo_expired = (tmo_cnt == TIMEOUT_WIDTH'(TIMEOUT_CYCLES - 1));
`else
    logic unused_timeout_cfg;

    assign unused_timeout_cfg = ^(TIMEOUT_WIDTH'(TIMEOUT_CYCLES));
`endif

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= S_EMPTY;
        end else begin
            state <= state_next;
        end
    end

    // A done pulse only matters in the state that owns the buffer; it beats a watchdog expiry.
    always_comb begin
        state_next = state;
        case (state)
            S_EMPTY: begin
                if (prod_req) begin
                    state_next = S_PROD;
                end
            end
            S_PROD: begin
                if (prod_done) begin
                    state_next = S_FULL;
                end
`ifdef POOL_ARB_TIMEOUT_EN
                else if (tmo_expired) begin
                    state_next = S_EMPTY;
                end
`endif
            end
            S_FULL: begin
                if (cons_req) begin
                    state_next = S_CONS;
                end
            end
            S_CONS: begin
                if (cons_done) begin
                    state_next = S_EMPTY;
                end
`ifdef POOL_ARB_TIMEOUT_EN
                else if (tmo_expired) begin
                    state_next = S_EMPTY;
                end
`endif
            end
            default: state_next = S_EMPTY;
        endcase
    end

    always_comb begin
        prod_gnt   = 1'b0;
        cons_gnt   = 1'b0;
        buf_full   = 1'b0;
        mem_addr_a = '0;
        mem_addr_b = '0;
        mem_rden_a = 1'b0;
        mem_rden_b = 1'b0;
        mem_wren_a = 1'b0;
        mem_wren_b = 1'b0;
        case (state)
            S_PROD: begin
                prod_gnt   = 1'b1;
                mem_addr_a = prod_addr_a;
                mem_addr_b = prod_addr_b;
                mem_rden_a = prod_rden_a;
                mem_rden_b = prod_rden_b;
                mem_wren_a = prod_wren_a;
                mem_wren_b = prod_wren_b;
            end
            S_FULL: begin
                buf_full = 1'b1;
            end
            S_CONS: begin
                cons_gnt   = 1'b1;
                buf_full   = 1'b1;
                mem_addr_a = cons_addr_a;
                mem_addr_b = cons_addr_b;
                mem_rden_a = cons_rden_a;
                mem_rden_b = cons_rden_b;
                mem_wren_a = cons_wren_a;
                mem_wren_b = cons_wren_b;
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            frame_cnt <= '0;
        end else if (state == S_CONS && cons_done) begin
            frame_cnt <= frame_cnt + 1'b1;
        end
    end

    // Sticky flag for any requester touching the memory without owning it.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            viol <= 1'b0;
        end else if ((prod_any_en && state != S_PROD) || (cons_any_en && state != S_CONS)) begin
            viol <= 1'b1;
        end
    end

`ifdef POOL_ARB_TIMEOUT_EN
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            tmo_cnt <= '0;
        end else if (state_next != state) begin
            tmo_cnt <= '0;
        end else if (state == S_PROD || state == S_CONS) begin
            tmo_cnt <= tmo_cnt + 1'b1;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            timeout_err <= 1'b0;
        end else if (tmo_expired && ((state == S_PROD && !prod_done) ||
                                     (state == S_CONS && !cons_done))) begin
            timeout_err <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_pool_mem_arbiter.sv
// Randomized scoreboard bench for pool_mem_arbiter against an ownership-level reference model.
// Define POOL_ARB_TIMEOUT_EN to also exercise the watchdog with a 16-cycle limit.
module tb_pool_mem_arbiter;

    localparam int AW = 10;
    localparam int FW = 8;
`ifdef POOL_ARB_TIMEOUT_EN
    localparam int TMO = 16;
`else
    localparam int TMO = 0;
`endif

    logic          clock;
    logic          reset;
    logic          prod_req, prod_done, cons_req, cons_done;
    logic [AW-1:0] prod_addr_a, prod_addr_b, cons_addr_a, cons_addr_b;
    logic          prod_rden_a, prod_rden_b, prod_wren_a, prod_wren_b;
    logic          cons_rden_a, cons_rden_b, cons_wren_a, cons_wren_b;
    logic          prod_gnt, cons_gnt, buf_full, viol;
    logic [AW-1:0] mem_addr_a, mem_addr_b;
    logic          mem_rden_a, mem_rden_b, mem_wren_a, mem_wren_b;
    logic [FW-1:0] frame_cnt;
    logic          timeout_err_obs;

    pool_mem_arbiter #(
        .POOL_ADDR_WIDTH(AW),
        .FRAME_CNT_WIDTH(FW)
`ifdef POOL_ARB_TIMEOUT_EN
        ,
        .TIMEOUT_CYCLES(16),
        .TIMEOUT_WIDTH(13)
`endif
    ) dut (
        .clock(clock), .reset(reset),
        .prod_req(prod_req), .prod_done(prod_done),
        .prod_addr_a(prod_addr_a), .prod_addr_b(prod_addr_b),
        .prod_rden_a(prod_rden_a), .prod_rden_b(prod_rden_b),
        .prod_wren_a(prod_wren_a), .prod_wren_b(prod_wren_b),
        .cons_req(cons_req), .cons_done(cons_done),
        .cons_addr_a(cons_addr_a), .cons_addr_b(cons_addr_b),
        .cons_rden_a(cons_rden_a), .cons_rden_b(cons_rden_b),
        .cons_wren_a(cons_wren_a), .cons_wren_b(cons_wren_b),
        .prod_gnt(prod_gnt), .cons_gnt(cons_gnt), .buf_full(buf_full),
        .mem_addr_a(mem_addr_a), .mem_addr_b(mem_addr_b),
        .mem_rden_a(mem_rden_a), .mem_rden_b(mem_rden_b),
        .mem_wren_a(mem_wren_a), .mem_wren_b(mem_wren_b),
        .frame_cnt(frame_cnt), .viol(viol)
`ifdef POOL_ARB_TIMEOUT_EN
        ,
        .timeout_err(timeout_err_obs)
`endif
    );

`ifndef POOL_ARB_TIMEOUT_EN
    assign timeout_err_obs = 1'b0;
`endif

    typedef struct {
        logic          pg, cg, bf;
        logic [AW-1:0] aa, ab;
        logic [3:0]    en;
        logic [FW-1:0] fc;
        logic          vl, te;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad = 0;

    // Reference model: who owns the buffer, whether it holds a frame, and bookkeeping.
    int   m_owner = 0;     // 0 nobody, 1 producer, 2 consumer
    bit   m_full = 0;
    int   m_frames = 0;
    int   m_frames_total = 0;
    int   m_owned = 0;
    bit   m_viol = 0;
    bit   m_tmo = 0;
    int   m_timeouts = 0;

    bit   rst_val = 0;
    bit   done_en = 1;
    bit   viol_en = 0;

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_clear();
        m_owner = 0; m_full = 0; m_frames = 0; m_owned = 0; m_viol = 0; m_tmo = 0;
    endtask

    task automatic model_step();
        bit p_any, c_any;
        p_any = prod_rden_a | prod_rden_b | prod_wren_a | prod_wren_b;
        c_any = cons_rden_a | cons_rden_b | cons_wren_a | cons_wren_b;
        if ((p_any && m_owner != 1) || (c_any && m_owner != 2)) m_viol = 1;
        case (m_owner)
            0: begin
                if (!m_full && prod_req) begin m_owner = 1; m_owned = 0; end
                else if (m_full && cons_req) begin m_owner = 2; m_owned = 0; end
            end
            1: begin
                if (prod_done) begin m_owner = 0; m_full = 1; end
                else if (TMO > 0 && m_owned == TMO - 1) begin m_owner = 0; m_tmo = 1; m_timeouts++; end
                else m_owned++;
            end
            default: begin
                if (cons_done) begin
                    m_owner = 0; m_full = 0;
                    m_frames = (m_frames + 1) % (1 << FW);
                    m_frames_total++;
                end
                else if (TMO > 0 && m_owned == TMO - 1) begin
                    m_owner = 0; m_full = 0; m_tmo = 1; m_timeouts++;
                end
                else m_owned++;
            end
        endcase
    endtask

    // One cycle: drive random inputs at the falling edge, queue the expected outputs, advance the model.
    task automatic apply_stimulus();
        exp_t e;
        bit   pe, ce;
        @(negedge clock);
        reset       = rst_val;
        prod_req    = ($urandom_range(3) != 0);
        cons_req    = ($urandom_range(3) != 0);
        prod_done   = done_en && ($urandom_range(3) == 0);
        cons_done   = done_en && ($urandom_range(3) == 0);
        pe = (m_owner == 1) || (viol_en && $urandom_range(15) == 0);
        ce = (m_owner == 2) || (viol_en && $urandom_range(15) == 0);
        prod_addr_a = AW'($urandom); prod_addr_b = AW'($urandom);
        cons_addr_a = AW'($urandom); cons_addr_b = AW'($urandom);
        prod_rden_a = pe & $urandom_range(1); prod_rden_b = pe & $urandom_range(1);
        prod_wren_a = pe & $urandom_range(1); prod_wren_b = pe & $urandom_range(1);
        cons_rden_a = ce & $urandom_range(1); cons_rden_b = ce & $urandom_range(1);
        cons_wren_a = ce & $urandom_range(1); cons_wren_b = ce & $urandom_range(1);
        if (!rst_val) model_clear();
        e.pg = (m_owner == 1);
        e.cg = (m_owner == 2);
        e.bf = m_full;
        e.aa = '0; e.ab = '0; e.en = '0;
        if (m_owner == 1) begin
            e.aa = prod_addr_a; e.ab = prod_addr_b;
            e.en = {prod_rden_a, prod_rden_b, prod_wren_a, prod_wren_b};
        end else if (m_owner == 2) begin
            e.aa = cons_addr_a; e.ab = cons_addr_b;
            e.en = {cons_rden_a, cons_rden_b, cons_wren_a, cons_wren_b};
        end
        e.fc = FW'(m_frames);
        e.vl = m_viol;
        e.te = m_tmo;
        exp_q.push_back(e);
        if (rst_val) model_step();
    endtask

    // Monitor: compares everything the DUT presents after the inputs have settled.
    initial begin
        exp_t e;
        forever begin
            @(negedge clock);
            #2;
            while (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check_output("prod_gnt", 32'(prod_gnt), 32'(e.pg));
                check_output("cons_gnt", 32'(cons_gnt), 32'(e.cg));
                check_output("buf_full", 32'(buf_full), 32'(e.bf));
                check_output("mem_addr_a", 32'(mem_addr_a), 32'(e.aa));
                check_output("mem_addr_b", 32'(mem_addr_b), 32'(e.ab));
                check_output("mem_enables", 32'({mem_rden_a, mem_rden_b, mem_wren_a, mem_wren_b}), 32'(e.en));
                check_output("frame_cnt", 32'(frame_cnt), 32'(e.fc));
                check_output("viol", 32'(viol), 32'(e.vl));
                check_output("timeout_err", 32'(timeout_err_obs), 32'(e.te));
                check_output("gnt_onehot", 32'(prod_gnt & cons_gnt), 32'(0));
            end
        end
    end

    initial begin
        int cyc;
        reset = 1'b0;
        {prod_req, prod_done, cons_req, cons_done} = '0;
        {prod_addr_a, prod_addr_b, cons_addr_a, cons_addr_b} = '0;
        {prod_rden_a, prod_rden_b, prod_wren_a, prod_wren_b} = '0;
        {cons_rden_a, cons_rden_b, cons_wren_a, cons_wren_b} = '0;

        rst_val = 0;
        repeat (6) apply_stimulus();
        rst_val = 1;

        // Well-behaved traffic first so viol must stay clear.
        repeat (200) apply_stimulus();

`ifdef POOL_ARB_TIMEOUT_EN
        done_en = 0;
        repeat (60) apply_stimulus();
        done_en = 1;
        if (m_timeouts == 0) begin
            total++; bad++;
            $display("[TB] FAIL watchdog_release: got 0 timeouts expected at least 1");
        end
`endif

        viol_en = 1;
        repeat (100) apply_stimulus();
        viol_en = 0;

        cyc = 0;
        while (m_frames_total < 260 && cyc < 20000) begin
            apply_stimulus();
            cyc++;
        end
        total++;
        if (m_frames_total < 260) begin
            bad++;
            $display("[TB] FAIL frame_wrap_budget: got %0d frames expected 260", m_frames_total);
        end

        cyc = 0;
        while (m_owner != 2 && cyc < 1000) begin
            apply_stimulus();
            cyc++;
        end
        total++;
        if (m_owner != 2) begin
            bad++;
            $display("[TB] FAIL reach_cons: got owner %0d expected 2", m_owner);
        end
        rst_val = 0;
        repeat (3) apply_stimulus();
        rst_val = 1;
        repeat (50) apply_stimulus();

        @(negedge clock);
        #5;
        check_output("queue_drained", 32'(exp_q.size()), 32'(0));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("[TB] FAIL sim_timeout: got no finish expected finish before limit");
        $fatal(1, "[TB] simulation time limit");
    end

endmodule

// File: doc/pool_mem_arbiter.md
Name: pool_mem_arbiter

Overview:
- Owns the pool output memory ports of a conv layer.
- Shares the ports between the producer (current layer's pool/no-pool writer) and the consumer (next layer's reader).
- Single-buffer ownership FSM: producer writes a full frame, consumer then reads it, then the buffer returns to the producer.
- Drives the memory's address/rden/wren "use" inputs; the two requesters never touch the RAM directly.

Parameters:
- POOL_ADDR_WIDTH, 10, memory address width.
- FRAME_CNT_WIDTH, 8, width of completed-frame counter.
- TIMEOUT_CYCLES, 4096, watchdog limit (optional feature only).
- TIMEOUT_WIDTH, 13, watchdog counter width; must hold TIMEOUT_CYCLES.

Ports:
- clock  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low reset
- prod_req  in  1  producer requests buffer (level, held until done)
- prod_done  in  1  producer frame complete (1-cycle pulse)
- prod_addr_a / prod_addr_b  in  POOL_ADDR_WIDTH each  producer addresses
- prod_rden_a / prod_rden_b / prod_wren_a / prod_wren_b  in  1 each  producer enables
- cons_req  in  1  consumer requests buffer (level)
- cons_done  in  1  consumer frame read complete (1-cycle pulse)
- cons_addr_a / cons_addr_b  in  POOL_ADDR_WIDTH each  consumer addresses
- cons_rden_a / cons_rden_b / cons_wren_a / cons_wren_b  in  1 each  consumer enables
- prod_gnt  out  1  producer owns memory
- cons_gnt  out  1  consumer owns memory
- buf_full  out  1  buffer holds an unread frame
- mem_addr_a / mem_addr_b  out  POOL_ADDR_WIDTH each  to memory address_a/address_b
- mem_rden_a / mem_rden_b / mem_wren_a / mem_wren_b  out  1 each  to memory
- frame_cnt  out  FRAME_CNT_WIDTH  frames fully consumed, wraps
- viol  out  1  sticky: non-owner asserted any rden/wren

Behaviour:
- Reset (reset=0, async): state S_EMPTY. All outputs 0: gnt, buf_full, mem_* enables and addresses, frame_cnt, viol.
- States: S_EMPTY, S_PROD, S_FULL, S_CONS. Encoding is free.
- S_EMPTY: prod_req=1 -> S_PROD. cons_req is ignored because there is no valid data.
- S_PROD: prod_gnt=1, registered (asserted the cycle after the req is sampled; 1-cycle grant latency). prod_done=1 -> S_FULL; prod_gnt drops the next cycle.
- S_FULL: buf_full=1. cons_req=1 -> S_CONS. prod_req is ignored (producer stalls).
- S_CONS: cons_gnt=1, buf_full stays 1. cons_done=1 -> S_EMPTY, buf_full->0, frame_cnt+1 (modulo 2^FRAME_CNT_WIDTH, 255->0 at default).
- Done pulse arriving in the same cycle as the req that wins the grant: done is ignored; a done only counts in the owning state.
- Done pulse in a non-owning state: ignored, no state change.
- Memory mux is combinational from state:
  - S_PROD passes prod_* through.
  - S_CONS passes cons_* through.
  - S_EMPTY/S_FULL force all four enables to 0 and both addresses to 0.
  - Zero added latency from requester input to mem_* output.
- prod_gnt and cons_gnt are never both 1 (one-hot-or-zero).
- viol: set when any prod enable=1 while not S_PROD, or any cons enable=1 while not S_CONS. Offending enables are still masked. Cleared only by reset.
- Reset asserted mid-frame: immediate return to S_EMPTY. The partial frame is discarded and frame_cnt is not incremented.

Optional Feature:
- Macro POOL_ARB_TIMEOUT_EN.
- When defined:
  - Counter starts at 0 on entry to S_PROD or S_CONS and increments each owned cycle.
  - Reaching TIMEOUT_CYCLES-1 without done forces release: S_PROD -> S_EMPTY, S_CONS -> S_EMPTY.
  - Sets extra output port timeout_err (1 bit, sticky, reset 0).
  - frame_cnt is not incremented on a timeout release.
- When undefined: no counter, no timeout_err port, ownership is held indefinitely.

Test Plan:
- Reset check: hold reset=0 with random inputs -> all outputs 0; release reset -> still S_EMPTY, gnts 0.
- Single frame: prod_req=1 at cycle 0 -> prod_gnt=1 at cycle 1; prod_wren_a=1, prod_addr_a=0x15 -> mem_wren_a=1, mem_addr_a=0x15 same cycle; prod_done at cycle 20 -> buf_full=1 at cycle 21; cons_req -> cons_gnt next cycle; cons_done -> buf_full=0, frame_cnt=1.
- Ordering: cons_req=1 from reset with buffer empty -> cons_gnt stays 0 until a producer frame completes; prod_req held in S_FULL -> prod_gnt 0 until cons_done.
- Violation: cons_rden_b=1 during S_PROD -> mem_rden_b=0, viol=1 and stays 1 through later frames.
- Wrap and abort: 256 complete frames -> frame_cnt=0; reset low mid-S_CONS -> S_EMPTY, frame_cnt=0, buf_full=0.
- POOL_ARB_TIMEOUT_EN, TIMEOUT_CYCLES=16: prod_req with no prod_done -> prod_gnt drops 16 cycles after grant, timeout_err=1, buf_full=0.
